// File: rtl/dot_operand_server_pkg.sv
// Shared types and constants for the dot-product operand server.
package dot_operand_server_pkg;

  // Controller phases: load operands, kick the engine, wait for it, hand off the result.
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    KICK  = 2'b01,
    BUSY  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  // Every bit of the captured result register comes out of reset at this value.
  localparam logic OUT_DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/dot_operand_server_operand_buffer.sv
// Operand storage: one write port, one zero-latency read port that returns 0
// for any address at or beyond the number of loaded entries.
module operand_buffer
  import dot_operand_server_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] count,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; the bound check keeps a stray write from ever landing past the array.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_A)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Range-guarded read: unloaded and out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    if (raddr < count) begin
      rdata = mem[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/dot_operand_server.sv
// Operand-side responder for the dot-product engine: loads (patch, filter)
// pairs, starts the engine, serves its reads and hands the result downstream.
module dot_operand_server
  import dot_operand_server_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_patch,
  input  logic [DATA_WIDTH-1:0] in_filter,
  input  logic                  in_last,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] vec_length,
  input  logic [ADDR_WIDTH-1:0] patch_addr,
  input  logic [ADDR_WIDTH-1:0] filter_addr,
  output logic [DATA_WIDTH-1:0] patch_data,
  output logic [DATA_WIDTH-1:0] filter_data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] count_inc;
  logic [ADDR_WIDTH-1:0] vec_length_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  load_fire;
  logic                  vec_end;

  assign count_inc = count_q + ONE_A;
  assign load_fire = in_valid && in_ready;
  // A vector closes on in_last or when the buffers fill; the fill case ignores in_last.
  assign vec_end   = in_last || (count_inc == DEPTH_A);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    start    = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && vec_end) state_d = KICK;
      end
      KICK: begin
        start   = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (done) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Load counter, latched vector length and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      vec_length_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_WIDTH{OUT_DATA_RST_BIT}};
    end else begin
      if (load_fire) begin
        count_q <= count_inc;
        if (vec_end) vec_length_q <= count_inc;
      end
      if ((state_q == BUSY) && done) begin
        out_data_q  <= result;
        out_valid_q <= 1'b1;
      end
      if ((state_q == DRAIN) && out_ready) begin
        out_valid_q  <= 1'b0;
        count_q      <= '0;
        vec_length_q <= '0;
      end
    end
  end

  assign vec_length = vec_length_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_patch_buf (
    .clk   (clk),
    .we    (load_fire),
    .waddr (count_q),
    .wdata (in_patch),
    .count (count_q),
    .raddr (patch_addr),
    .rdata (patch_data)
  );

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_filter_buf (
    .clk   (clk),
    .we    (load_fire),
    .waddr (count_q),
    .wdata (in_filter),
    .count (count_q),
    .raddr (filter_addr),
    .rdata (filter_data)
  );

endmodule

// File: tb/tb_dot_operand_server.sv
// Self-checking bench for dot_operand_server (DEPTH=4 to reach the fill guard).
module tb_dot_operand_server;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_patch;
  logic [DW-1:0] in_filter;
  logic          in_last;
  logic          start;
  logic [AW-1:0] vec_length;
  logic [AW-1:0] patch_addr;
  logic [AW-1:0] filter_addr;
  logic [DW-1:0] patch_data;
  logic [DW-1:0] filter_data;
  logic          done;
  logic [DW-1:0] result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  dot_operand_server #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_patch    (in_patch),
    .in_filter   (in_filter),
    .in_last     (in_last),
    .start       (start),
    .vec_length  (vec_length),
    .patch_addr  (patch_addr),
    .filter_addr (filter_addr),
    .patch_data  (patch_data),
    .filter_data (filter_data),
    .done        (done),
    .result      (result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pa;
    logic [AW-1:0] fa;
    logic [DW-1:0] ep;
    logic [DW-1:0] ef;
  } rd_vec_t;

  rd_vec_t rd_tab[5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_pair(input logic [DW-1:0] p, input logic [DW-1:0] f, input logic l);
    in_valid  = 1'b1;
    in_patch  = p;
    in_filter = f;
    in_last   = l;
    #1;
    chk("in_ready_load", DW'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Uses one clock cycle: apply addresses, check combinational data, advance.
  task automatic rd_chk(input logic [AW-1:0] pa, input logic [AW-1:0] fa,
                        input logic [DW-1:0] ep, input logic [DW-1:0] ef);
    patch_addr  = pa;
    filter_addr = fa;
    #1;
    chk("patch_data", patch_data, ep);
    chk("filter_data", filter_data, ef);
    @(negedge clk);
  endtask

  // From BUSY: pulse done, stall the consumer, then accept.
  task automatic finish_run(input logic [DW-1:0] res, input int stall);
    done   = 1'b1;
    result = res;
    @(negedge clk);
    done = 1'b0;
    chk("out_valid_cap", DW'(out_valid), 1);
    chk("out_data_cap", out_data, res);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("out_valid_stall", DW'(out_valid), 1);
      chk("out_data_stall", out_data, res);
      chk("in_ready_drain", DW'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clr", DW'(out_valid), 0);
    chk("in_ready_back", DW'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] mp[$];
    logic [DW-1:0] mf[$];
    logic [DW-1:0] p, f, ep, ef;
    int            len, pa, fa;
    logic          last;

    rd_tab[0] = '{10'd0, 10'd0, 32'h3F800000, 32'h40000000};
    rd_tab[1] = '{10'd1, 10'd2, 32'h40400000, 32'h40C00000};
    rd_tab[2] = '{10'd3, 10'd3, 32'h00000000, 32'h00000000};
    rd_tab[3] = '{10'd2, 10'd1, 32'h40A00000, 32'h40800000};
    rd_tab[4] = '{10'd4, 10'd1023, 32'h00000000, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; in_patch = '0; in_filter = '0; in_last = 1'b0;
    patch_addr = '0; filter_addr = '0; done = 1'b0; result = '0; out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_start", DW'(start), 0);
    chk("rst_vec_length", DW'(vec_length), 0);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_patch_data", patch_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", DW'(in_ready), 1);

    // Basic run and table-driven reads
    send_pair(32'h3F800000, 32'h40000000, 1'b0);
    send_pair(32'h40400000, 32'h40800000, 1'b0);
    send_pair(32'h40A00000, 32'h40C00000, 1'b1);
    chk("t1_start", DW'(start), 1);
    chk("t1_vec_length", DW'(vec_length), 3);
    chk("t1_in_ready_kick", DW'(in_ready), 0);
    @(negedge clk);
    chk("t1_start_pulse", DW'(start), 0);
    chk("t1_vec_length_hold", DW'(vec_length), 3);
    for (int i = 0; i < 5; i++) rd_chk(rd_tab[i].pa, rd_tab[i].fa, rd_tab[i].ep, rd_tab[i].ef);

    // Result capture with stall and a spurious done in DRAIN
    done = 1'b1; result = 32'h41F00000;
    @(negedge clk);
    done = 1'b0;
    chk("t2_out_valid", DW'(out_valid), 1);
    chk("t2_out_data", out_data, 32'h41F00000);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin done = 1'b1; result = 32'hDEADBEEF; end
      @(negedge clk);
      done = 1'b0;
      chk("t2_stall_valid", DW'(out_valid), 1);
      chk("t2_stall_data", out_data, 32'h41F00000);
      chk("t2_stall_in_ready", DW'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_out_valid_clr", DW'(out_valid), 0);
    chk("t2_in_ready", DW'(in_ready), 1);
    rd_chk(0, 0, 0, 0);

    // Spurious done in LOAD
    done = 1'b1; result = 32'h12345678;
    @(negedge clk);
    done = 1'b0;
    chk("t5_in_ready", DW'(in_ready), 1);
    chk("t5_start", DW'(start), 0);
    chk("t5_out_valid", DW'(out_valid), 0);
    chk("t5_out_data", out_data, 32'h41F00000);

    // Fill guard: DEPTH pairs without in_last
    for (int i = 0; i < DEPTH; i++) send_pair(32'hA0 + DW'(i), 32'hB0 + DW'(i), 1'b0);
    chk("t3_start", DW'(start), 1);
    chk("t3_vec_length", DW'(vec_length), DEPTH);
    chk("t3_in_ready", DW'(in_ready), 0);
    @(negedge clk);
    rd_chk(3, 3, 32'hA3, 32'hB3);
    rd_chk(4, 4, 0, 0);
    rd_chk(0, 2, 32'hA0, 32'hB2);
    done = 1'b1; result = 32'h55;
    @(negedge clk);
    done = 1'b0;
    chk("t3_out_data", out_data, 32'h55);
    // Load offered alongside the accepting out_ready must not be taken
    out_ready = 1'b1; in_valid = 1'b1; in_patch = 32'h77; in_filter = 32'h88; in_last = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("t3_in_ready_back", DW'(in_ready), 1);
    chk("t3_out_valid_clr", DW'(out_valid), 0);
    rd_chk(0, 0, 0, 0);
    chk("t3_no_start", DW'(start), 0);

    // Single-element vector
    send_pair(32'hCAFE0001, 32'hCAFE0002, 1'b1);
    chk("t4_start", DW'(start), 1);
    chk("t4_vec_length", DW'(vec_length), 1);
    @(negedge clk);
    rd_chk(0, 0, 32'hCAFE0001, 32'hCAFE0002);
    rd_chk(1, 1, 0, 0);
    finish_run(32'h0BADF00D, 1);

    // Reset while BUSY
    send_pair(32'h11, 32'h22, 1'b0);
    send_pair(32'h33, 32'h44, 1'b1);
    patch_addr = 0; filter_addr = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6b_out_valid", DW'(out_valid), 0);
    chk("t6b_start", DW'(start), 0);
    chk("t6b_vec_length", DW'(vec_length), 0);
    chk("t6b_patch_data", patch_data, 0);
    chk("t6b_filter_data", filter_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6b_in_ready", DW'(in_ready), 1);

    // Reset while DRAIN
    send_pair(32'h55, 32'h66, 1'b1);
    @(negedge clk);
    done = 1'b1; result = 32'h99;
    @(negedge clk);
    done = 1'b0;
    chk("t6d_out_valid_pre", DW'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6d_out_valid", DW'(out_valid), 0);
    chk("t6d_out_data", out_data, 0);
    chk("t6d_vec_length", DW'(vec_length), 0);
    chk("t6d_patch_data", patch_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6d_in_ready", DW'(in_ready), 1);
    send_pair(32'h77, 32'h78, 1'b1);
    chk("t6d_start", DW'(start), 1);
    chk("t6d_vec_length_new", DW'(vec_length), 1);
    @(negedge clk);
    finish_run(32'h1234, 0);

    // Randomised transactions against a queue-based model
    for (int t = 0; t < 30; t++) begin
      mp.delete();
      mf.delete();
      len = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_patch = $urandom; in_last = 1'b1;
          @(negedge clk);
          in_last = 1'b0;
        end
        p = $urandom;
        f = $urandom;
        last = (i == len - 1);
        send_pair(p, f, last);
        mp.push_back(p);
        mf.push_back(f);
        if (last || (mp.size() == DEPTH)) break;
      end
      chk("rnd_start", DW'(start), 1);
      chk("rnd_vec_length", DW'(vec_length), DW'(mp.size()));
      @(negedge clk);
      chk("rnd_busy_in_ready", DW'(in_ready), 0);
      for (int k = 0; k < 3; k++) begin
        pa = $urandom_range(0, DEPTH + 1);
        fa = $urandom_range(0, DEPTH + 1);
        ep = (pa < mp.size()) ? mp[pa] : '0;
        ef = (fa < mf.size()) ? mf[fa] : '0;
        rd_chk(AW'(pa), AW'(fa), ep, ef);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_busy_out_valid", DW'(out_valid), 0);
      end
      finish_run($urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
